// File: rtl/regfile_pkg.sv
// Shared constants and clear-sequencer state encoding for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } regfile_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, then hands the
// register file over to the datapath.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output regfile_state_t    state
);

    regfile_state_t    state_q;
    regfile_state_t    state_n;
    logic [ADDR_W-1:0] clr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == ST_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    // The write of the last address is the one that ends the sequence.
    always_comb begin
        state_n = state_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (clr_ptr == '1) begin
                    state_n = ST_READY;
                end
            end
            ST_READY: begin
                state_n = ST_READY;
            end
            default: begin
                state_n = ST_CLEAR;
            end
        endcase
    end

    assign clr_addr = clr_ptr;
    assign state    = state_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: N_RD combinational read ports, two write lanes (lane 1 wins),
// optional hardwired-zero entry 0, optional write-to-read bypass, post-reset clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_RD     = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD*DATA_W-1:0]   rd
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    regfile_state_t    seq_state;
    logic              clearing;
    logic              wr0;
    logic              wr1;

    regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .state    (seq_state)
    );

    assign clearing = (seq_state == ST_CLEAR);

    // Lane writes are qualified here so the bypass path sees exactly what gets stored.
    assign wr0 = we0 && !clearing && !(ZERO_REG && (wa0 == '0));
    assign wr1 = we1 && !clearing && !(ZERO_REG && (wa1 == '0));

    (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [DEPTH];

    // Lane 1 is assigned last so it overrides lane 0 on an address collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr0) begin
                mem[wa0] <= wd0;
            end
            if (wr1) begin
                mem[wa1] <= wd1;
            end
        end
    end

    for (genvar g = 0; g < N_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = ra[g*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem[addr];
            if (clearing) begin
                data = '0;
            end else if (ZERO_REG && (addr == '0)) begin
                data = '0;
            end else if (BYPASS && wr1 && (wa1 == addr)) begin
                data = wd1;
            end else if (BYPASS && wr0 && (wa0 == addr)) begin
                data = wd0;
            end
        end

        assign rd[g*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with zero-reg and bypass, one without.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [9:0]  ra;
    logic        busy_a;
    logic        busy_b;
    logic [63:0] rd_a;
    logic [63:0] rd_b;

    int total;
    int bad;
    int cnt;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
        logic [31:0] exp_b0;
        logic [31:0] exp_b1;
    } vec_t;

    vec_t vecs[13];

    regfile_mp dut_a (
        .clk(clk), .rst_n(rst_n), .busy(busy_a),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_a)
    );

    regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .busy(busy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        ra = {a1, a0};
    endtask

    // Counts posedges until busy falls on the default instance, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy_a && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) idle();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        set_ra(5'd5, 5'd31);

        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,
                     32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd0,
                     32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       5'd7,  5'd5,
                     32'h22,       32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7,
                     32'h22,       32'h22,       32'h22,       32'h22};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hABCD,     5'd9,  5'd9,
                     32'hABCD,     32'hABCD,     32'h0,        32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd9,
                     32'h0,        32'hABCD,     32'h0,        32'hABCD};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd9,
                     32'h0,        32'hABCD,     32'hFFFFFFFF, 32'hABCD};
        vecs[7]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd3,  32'hCAFEF00D, 5'd3,  5'd0,
                     32'hCAFEF00D, 32'h0,        32'h0,        32'hFFFFFFFF};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd0,
                     32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h12345678};
        vecs[9]  = '{1'b1, 5'd9,  32'h55,       1'b1, 5'd4,  32'h66,       5'd9,  5'd4,
                     32'h55,       32'h66,       32'hABCD,     32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd4,
                     32'h55,       32'h66,       32'h55,       32'h66};
        vecs[11] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 32'h5A5A5A5A, 5'd31, 5'd7,
                     32'h5A5A5A5A, 32'h22,       32'h0,        32'h22};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd30,
                     32'h5A5A5A5A, 32'h0,        32'h5A5A5A5A, 32'h0};

        // Reset held: busy and zero reads, even with a write presented.
        repeat (3) @(posedge clk);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1234;
        @(negedge clk);
        check("reset_busy_a", {31'd0, busy_a}, 32'd1);
        check("reset_busy_b", {31'd0, busy_b}, 32'd1);
        check("reset_rd_a0", rd_a[31:0], 32'h0);
        check("reset_rd_b0", rd_b[31:0], 32'h0);
        idle();

        // Release: busy for exactly 32 cycles.
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("clear_rd_a1", rd_a[63:32], 32'h0);
        check("clear_rd_b1", rd_b[63:32], 32'h0);
        @(posedge clk); #1;
        cnt = 1;
        while (busy_a && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("clear_len", cnt, 32'd32);
        check("clear_busy_b", {31'd0, busy_b}, 32'd0);

        // Sweep every address on both ports.
        for (int i = 0; i < 32; i++) begin
            set_ra(5'(i), 5'(31 - i));
            #1;
            check($sformatf("sweep_a_%0d", i), rd_a[31:0] | rd_a[63:32], 32'h0);
            check($sformatf("sweep_b_%0d", i), rd_b[31:0] | rd_b[63:32], 32'h0);
        end

        // Table: drive after posedge, sample combinational reads before the next posedge.
        for (int v = 0; v < 13; v++) begin
            @(posedge clk); #1;
            we0 = vecs[v].we0; wa0 = vecs[v].wa0; wd0 = vecs[v].wd0;
            we1 = vecs[v].we1; wa1 = vecs[v].wa1; wd1 = vecs[v].wd1;
            set_ra(vecs[v].ra0, vecs[v].ra1);
            @(negedge clk);
            check($sformatf("v%0d_busy", v), {31'd0, busy_a | busy_b}, 32'd0);
            check($sformatf("v%0d_a0", v), rd_a[31:0],  vecs[v].exp_a0);
            check($sformatf("v%0d_a1", v), rd_a[63:32], vecs[v].exp_a1);
            check($sformatf("v%0d_b0", v), rd_b[31:0],  vecs[v].exp_b0);
            check($sformatf("v%0d_b1", v), rd_b[63:32], vecs[v].exp_b1);
        end
        @(posedge clk); #1;
        idle();

        // Mid-clear reset: restart at clear cycle 10, a write during busy is lost.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("midclr_busy", {31'd0, busy_a}, 32'd1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h77;
        we1 = 1'b1; wa1 = 5'd5;  wd1 = 32'h99;
        set_ra(5'd12, 5'd5);
        @(negedge clk);
        check("midclr_rd_a", rd_a[31:0] | rd_a[63:32], 32'h0);
        count_busy(cnt);
        check("midclr_len", cnt, 32'd32);
        idle();
        #1;
        check("lost_a0", rd_a[31:0],  32'h0);
        check("lost_a1", rd_a[63:32], 32'h0);
        check("lost_b0", rd_b[31:0],  32'h0);
        check("lost_b1", rd_b[63:32], 32'h0);

        // Post-clear write still works.
        @(posedge clk); #1;
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h3C3C;
        @(posedge clk); #1;
        idle();
        #1;
        check("after_a0", rd_a[31:0], 32'h3C3C);
        check("after_b0", rd_b[31:0], 32'h3C3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
